// File: rtl/net_arb_pkg.sv
// Shared definitions for the network-arbiter trust sequencer: legal state
// words, FSM encoding and the state-word validity check.
package net_arb_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] STATE_TRUSTED   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] STATE_UNTRUSTED = 32'hF0F0_F0F0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Only the two defined trust words may ever reach the state register.
  function automatic logic is_valid_state(input logic [WORD_W-1:0] v);
    return (v == STATE_TRUSTED) || (v == STATE_UNTRUSTED);
  endfunction

endpackage

// File: rtl/network_arbiter_trust_sequencer_if.sv
// Requester / network / state-register bus of the trust sequencer.
//   req, req_value, net_busy : requester and network side inputs
//   ack, err                 : per-requester completion / error pulses
//   write_state_value, busy  : committed state word and sequencer activity
// master: requester/environment side; slave: the sequencer.
interface network_arbiter_trust_sequencer_if
  import net_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]        req;
  logic [WORD_W*NUM_REQ-1:0] req_value;
  logic                      net_busy;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [WORD_W-1:0]         write_state_value;
  logic                      busy;

  modport master (
    output req, req_value, net_busy,
    input  ack, err, write_state_value, busy
  );

  modport slave (
    input  req, req_value, net_busy,
    output ack, err, write_state_value, busy
  );

endinterface

// File: rtl/net_arb_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping at NUM_REQ.
//   req_i         : request levels
//   ptr_i         : round-robin start index
//   gnt_idx_c_o   : index of the winning requester
//   gnt_valid_c_o : at least one request is set
module net_arb_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   gnt_idx_c_o,
  output logic               gnt_valid_c_o
);

  localparam int N = int'(NUM_REQ);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt_idx_c_o   = '0;
    gnt_valid_c_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[IDX_W'((int'(ptr_i) + k) % N)]) begin
        gnt_idx_c_o   = IDX_W'((int'(ptr_i) + k) % N);
        gnt_valid_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/network_arbiter_trust_sequencer.sv
// Trust-state sequencer: round-robin grants a requester, validates its state
// word, waits for the network to drain, commits the word to the state
// register, holds a settle window, then acknowledges.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_if     : slave side of network_arbiter_trust_sequencer_if
// Optional build macro NET_ARB_DRAIN_TIMEOUT_EN: abort DRAIN with an error
// after DRAIN_TIMEOUT busy cycles (otherwise DRAIN waits indefinitely).
module network_arbiter_trust_sequencer
  import net_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  network_arbiter_trust_sequencer_if.slave bus_if
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (SETTLE_CYCLES < 1) || (DRAIN_TIMEOUT < 1)) begin : g_bad_params
    $error("network_arbiter_trust_sequencer: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [WORD_W-1:0]  val_q, val_d;
  logic [WORD_W-1:0]  wsv_q, wsv_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [WORD_W-1:0]  pick_val;
  logic [WORD_W-1:0]  req_words [NUM_REQ];
  logic               drain_timeout_c;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_words
    assign req_words[i] = bus_if.req_value[WORD_W*i +: WORD_W];
  end

`ifdef NET_ARB_DRAIN_TIMEOUT_EN
  localparam int unsigned DTO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [DTO_W-1:0] drain_cnt_q, drain_cnt_d;

  // Fires on the DRAIN_TIMEOUT-th consecutive busy cycle spent in DRAIN.
  assign drain_timeout_c = bus_if.net_busy && (drain_cnt_q == DTO_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drain_cnt_q <= '0;
    else        drain_cnt_q <= drain_cnt_d;
  end
`else
  assign drain_timeout_c = 1'b0;
`endif

  net_arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i         (bus_if.req),
    .ptr_i         (rr_ptr_q),
    .gnt_idx_c_o   (pick_idx),
    .gnt_valid_c_o (pick_vld)
  );

  assign pick_val = req_words[pick_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          // Invalid words and no-op requests skip straight to the ACK.
          if (!is_valid_state(pick_val) || (pick_val == wsv_q)) state_d = ST_DONE;
          else                                                  state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus_if.net_busy)     state_d = ST_SETTLE;
        else if (drain_timeout_c) state_d = ST_DONE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    val_d        = val_q;
    wsv_d        = wsv_q;
    err_flag_d   = err_flag_q;
    settle_cnt_d = settle_cnt_q;
    ack_d        = '0;
    err_d        = '0;
    busy_d       = (state_d != ST_IDLE);
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
    drain_cnt_d  = drain_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d      = pick_idx;
          val_d      = pick_val;
          err_flag_d = !is_valid_state(pick_val);
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
          drain_cnt_d = '0;
`endif
        end
      end
      ST_DRAIN: begin
        if (!bus_if.net_busy) begin
          // The only place the committed state word ever changes.
          wsv_d        = val_q;
          settle_cnt_d = '0;
        end else begin
          err_flag_d = drain_timeout_c;
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
          drain_cnt_d = drain_cnt_q + DTO_W'(1);
`endif
        end
      end
      ST_SETTLE: settle_cnt_d = settle_cnt_q + CNT_W'(1);
      ST_DONE:   rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
      default: ;
    endcase
    // ACK/ERR decoded from the next state so they are high exactly in DONE.
    if (state_d == ST_DONE) begin
      ack_d[gnt_d] = 1'b1;
      err_d[gnt_d] = err_flag_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      val_q        <= '0;
      wsv_q        <= STATE_TRUSTED;
      err_flag_q   <= 1'b0;
      settle_cnt_q <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      val_q        <= val_d;
      wsv_q        <= wsv_d;
      err_flag_q   <= err_flag_d;
      settle_cnt_q <= settle_cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_if.ack               = ack_q;
  assign bus_if.err               = err_q;
  assign bus_if.write_state_value = wsv_q;
  assign bus_if.busy              = busy_q;

endmodule
